// File: rtl/reset_seq_pkg.sv
// Shared types and constant helpers for the staged channel reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRE     = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter; parks at zero and flags it for the sequencer FSM.
module rst_seq_cnt #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)           cnt_d = load_val_i;
    else if (cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Staged active-low channel reset generator: power-on sequence after system reset,
// maskable soft sequence (pre-delay, assert, hold, staggered release) on request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int PRE_CYCLES     = 30,
  parameter int HOLD_CYCLES    = 50,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              rst_req_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  output logic [NUM_CH-1:0] ch_resetn_o,
  output logic              rst_busy_o,
  output logic              rst_done_o
);

  localparam int CNT_W = clog2(max2(max2(PRE_CYCLES, HOLD_CYCLES), STAGGER_CYCLES) + 1);
  localparam int IDX_W = max2(clog2(NUM_CH), 1);

  // A counter loaded with N-1 on entry reaches zero exactly N edges later.
  localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ld_q;
  logic              cnt_ld;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;

  rst_seq_cnt #(.W(CNT_W)) u_cnt (
    .clk_i      (sys_clk),
    .rst_i      (sys_reset),
    .load_i     (cnt_ld),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cnt_ld  = 1'b0;
    cnt_val = '0;
    // First edge out of system reset is the HOLD entry of the power-on sequence.
    if (ld_q) begin
      cnt_ld  = 1'b1;
      cnt_val = HOLD_LD;
    end else begin
      case (state_q)
        IDLE: begin
          if (rst_req_i) begin
            state_d = PRE;
            mask_d  = ch_mask_i;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            cnt_ld  = 1'b1;
            cnt_val = PRE_LD;
          end
        end
        PRE: begin
          if (cnt_zero) begin
            state_d = HOLD;
            ch_d    = mask_q;
            cnt_ld  = 1'b1;
            cnt_val = HOLD_LD;
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            ch_d[0] = 1'b1;
            if (NUM_CH == 1) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
              idx_d   = IDX_W'(1);
              cnt_ld  = 1'b1;
              cnt_val = STAG_LD;
            end
          end
        end
        RELEASE: begin
          if (cnt_zero) begin
            ch_d[idx_q] = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              cnt_ld  = 1'b1;
              cnt_val = STAG_LD;
            end
          end
        end
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q <= HOLD;
      mask_q  <= '0;
      ch_q    <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ld_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ld_q    <= 1'b0;
    end
  end

  assign ch_resetn_o = ch_q;
  assign rst_busy_o  = busy_q;
  assign rst_done_o  = done_q;

endmodule
